composite_sync_generator: RTL

- Composite video timing and level generator. It is the transmit-side counterpart of the composite sync separator.
- It produces a 12-bit sample stream with sync tips, blanking and active luma. The stream drives a video DAC, or feeds the capture path directly for loopback test.
- It runs on the 73.8 MHz system clock and advances one sample per sample_tick (36.9 MHz).
- Line and frame timing are chosen so the separator's H/V detection and back-porch window lock onto the output.

---
 rtl/composite_sync_generator.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/composite_sync_generator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// composite_sync_generator
//
// Transmit-side composite video timing and level generator. Produces a
// 12-bit DAC sample stream (sync tips, blanking, active luma) whose line and
// frame timing the composite sync separator locks onto. One sample is
// produced per sample_tick. While run is low the generator idles at the
// blanking level with its counters held at the frame origin. The first tick
// with run high emits the h=0, v=0 sample, so the output always restarts
// exactly at frame start.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   sample_tick  in   sample enable; state advances only on ticks
//   run          in   generator enable (low = idle at blank level)
//   luma[7:0]    in   pixel luma for the position flagged by pixel_req
//   pixel_req    out  combinational; counters inside active window and run=1
//   x_coord[11:0] out current sample counter h
//   y_coord[9:0] out  current line counter v
//   dac_data[11:0] out registered composite sample code
//   h_sync_pulse out  registered strobe with the h=0 sample of every line
//   v_sync_pulse out  registered strobe with the h=0, v=0 sample
//   active_video out  registered; high when dac_data carries luma
// ---------------------------------------------------------------------------
module composite_sync_generator #(
    parameter int LINE_SAMPLES      = 2343,
    parameter int FRAME_LINES       = 262,
    parameter int HSYNC_WIDTH       = 173,
    parameter int VSYNC_LINES       = 3,
    parameter int VSYNC_LOW_WIDTH   = 2000,
    parameter int BACK_PORCH        = 176,
    parameter int ACTIVE_WIDTH      = 1920,
    parameter int FIRST_ACTIVE_LINE = 20,
    parameter int ACTIVE_LINES      = 240,
    parameter int SYNC_LEVEL        = 2400,
    parameter int BLANK_LEVEL       = 3100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        run,
    input  logic [7:0]  luma,
    output logic        pixel_req,
    output logic [11:0] x_coord,
    output logic [9:0]  y_coord,
    output logic [11:0] dac_data,
    output logic        h_sync_pulse,
    output logic        v_sync_pulse,
    output logic        active_video
);

    localparam logic [11:0] H_LAST      = 12'(LINE_SAMPLES - 1);
    localparam logic [9:0]  V_LAST      = 10'(FRAME_LINES - 1);
    localparam logic [9:0]  V_BROAD_END = 10'(VSYNC_LINES);
    localparam logic [11:0] H_BROAD_TIP = 12'(VSYNC_LOW_WIDTH);
    localparam logic [11:0] H_TIP       = 12'(HSYNC_WIDTH);
    localparam logic [11:0] H_ACT_START = 12'(HSYNC_WIDTH + BACK_PORCH);
    localparam logic [11:0] H_ACT_END   = 12'(HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH);
    localparam logic [9:0]  V_ACT_START = 10'(FIRST_ACTIVE_LINE);
    localparam logic [9:0]  V_ACT_END   = 10'(FIRST_ACTIVE_LINE + ACTIVE_LINES);
    localparam logic [11:0] SYNC_CODE   = 12'(SYNC_LEVEL);
    localparam logic [11:0] BLANK_CODE  = 12'(BLANK_LEVEL);

    // Blank offset plus luma*4, evaluated in 13 bits and clamped to full scale.
    function automatic logic [11:0] luma_code(input logic [7:0] y);
        logic [12:0] sum;
        sum = {1'b0, BLANK_CODE} + {3'b000, y, 2'b00};
        if (sum[12]) begin
            return 12'hFFF;
        end else begin
            return sum[11:0];
        end
    endfunction

    logic [11:0] h_r;
    logic [9:0]  v_r;
    logic [11:0] h_nxt_s;
    logic [9:0]  v_nxt_s;
    logic        broad_s;
    logic        tip_s;
    logic        window_s;
    logic [11:0] level_s;
    logic [11:0] dac_r;
    logic        hs_r;
    logic        vs_r;
    logic        act_r;

    // Raster position one sample ahead: wrap h at line end, v at frame end.
    always_comb begin
        h_nxt_s = h_r + 12'd1;
        v_nxt_s = v_r;
        if (h_r == H_LAST) begin
            h_nxt_s = 12'd0;
            if (v_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_r + 10'd1;
            end
        end else begin
            v_nxt_s = v_r;
        end
    end

    // Classify the current position: broad/normal line, sync tip, active window.
    always_comb begin
        broad_s  = (v_r < V_BROAD_END);
        tip_s    = 1'b0;
        window_s = 1'b0;
        if (broad_s) begin
            // Broad lines carry one long tip and never any picture.
            tip_s    = (h_r < H_BROAD_TIP);
            window_s = 1'b0;
        end else begin
            tip_s    = (h_r < H_TIP);
            window_s = (v_r >= V_ACT_START) && (v_r < V_ACT_END) &&
                       (h_r >= H_ACT_START) && (h_r < H_ACT_END);
        end
    end

    // Sample level for the current position; sync tip wins over everything.
    always_comb begin
        level_s = BLANK_CODE;
        if (tip_s) begin
            level_s = SYNC_CODE;
        end else if (window_s) begin
            level_s = luma_code(luma);
        end else begin
            level_s = BLANK_CODE;
        end
    end

    // Counters and registered outputs. Idle (run low on a tick) parks the
    // counters at the origin so the next running tick emits the h=0, v=0
    // sample; a dropped run forces blank even inside a sync tip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r   <= 12'd0;
            v_r   <= 10'd0;
            dac_r <= BLANK_CODE;
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            act_r <= 1'b0;
        end else if (sample_tick) begin
            if (run) begin
                h_r   <= h_nxt_s;
                v_r   <= v_nxt_s;
                dac_r <= level_s;
                hs_r  <= (h_r == 12'd0);
                vs_r  <= (h_r == 12'd0) && (v_r == 10'd0);
                act_r <= window_s;
            end else begin
                h_r   <= 12'd0;
                v_r   <= 10'd0;
                dac_r <= BLANK_CODE;
                hs_r  <= 1'b0;
                vs_r  <= 1'b0;
                act_r <= 1'b0;
            end
        end
    end

    assign pixel_req    = run & window_s;
    assign x_coord      = h_r;
    assign y_coord      = v_r;
    assign dac_data     = dac_r;
    assign h_sync_pulse = hs_r;
    assign v_sync_pulse = vs_r;
    assign active_video = act_r;

    composite_sync_generator_checker #(
        .LINE_SAMPLES    (LINE_SAMPLES),
        .HSYNC_WIDTH     (HSYNC_WIDTH),
        .BACK_PORCH      (BACK_PORCH),
        .ACTIVE_WIDTH    (ACTIVE_WIDTH),
        .VSYNC_LOW_WIDTH (VSYNC_LOW_WIDTH)
    ) u_checker (
        .clk (clk)
    );

endmodule

// ---------------------------------------------------------------------------
// composite_sync_generator_checker
//
// Simulation-only parameter sanity checks for the generator.
// Ports:
//   clk  in  clock on which the checks are evaluated
// ---------------------------------------------------------------------------
module composite_sync_generator_checker #(
    parameter int LINE_SAMPLES    = 2343,
    parameter int HSYNC_WIDTH     = 173,
    parameter int BACK_PORCH      = 176,
    parameter int ACTIVE_WIDTH    = 1920,
    parameter int VSYNC_LOW_WIDTH = 2000
) (
    input logic clk
);

    // The active window must end inside the line it starts on.
    a_window_fits: assert property (@(posedge clk)
        (HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH) <= LINE_SAMPLES);

    // A broad pulse must release before the line ends.
    a_broad_fits: assert property (@(posedge clk)
        VSYNC_LOW_WIDTH < LINE_SAMPLES);

endmodule
